compute_tile_pe: RTL and testbench
==================================

COMPUTE_TILE_PE -- requirements
Module: compute_tile_pe

Interface
REQ-001 Parameter DW, default 8, data width in bits; legal DW >= 4+DSTW.
REQ-002 Parameter WDEPTH, default 4, number of weight registers; SELW = max(1, clog2(WDEPTH)).
REQ-003 Parameter NCORES, default 4, number of reachable downstream tiles; DSTW = max(1, clog2(NCORES)).
REQ-004 clk  input  1  clock; all state is updated on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  input packet present.
REQ-007 in_ready  output  1  tile accepts a packet this cycle.
REQ-008 in_type  input  2  packet type: 00 LOAD_W, 01 CONFIG, 10 DATA, 11 FLUSH.
REQ-009 in_sel  input  SELW  weight index for LOAD_W and CONFIG.
REQ-010 in_data  input  DW  packet payload.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_data  output  DW  result value.
REQ-014 out_dest  output  DSTW  destination tile index of the result.
REQ-015 out_has_dest  output  1  a destination was configured.

Function
REQ-016 A packet SHALL be accepted only in a cycle where in_valid && in_ready; in_ready SHALL be 1 exactly in state IDLE.
REQ-017 The state machine SHALL have states IDLE, BUSY and HOLD.
REQ-018 LOAD_W SHALL write weight[in_sel] <= in_data and remain in IDLE; if in_sel >= WDEPTH the packet SHALL be dropped.
REQ-019 CONFIG SHALL latch op = in_data[2:0], sat = in_data[3], dest = in_data[4 +: DSTW], wsel = in_sel, and set has_dest = 1; it SHALL remain in IDLE and affect only later packets.
REQ-020 Op codes: 000 ADD, 001 SUB, 010 MUL, 011 MAC, 100 MAX; codes 101-111 SHALL behave as ADD.
REQ-021 ADD/SUB/MAX on a DATA packet: the result SHALL be registered and the machine SHALL go IDLE->HOLD, so out_valid rises the cycle after acceptance.
REQ-022 ADD and SUB SHALL wrap modulo 2^DW when sat=0.
REQ-023 With sat=1, ADD SHALL clamp to 2^DW-1 and SUB SHALL clamp to 0.
REQ-024 MAX SHALL output the unsigned maximum of in_data and weight[wsel].
REQ-025 MUL/MAC on a DATA packet: the machine SHALL go IDLE->BUSY and compute the product with an iterative shift-add over DW cycles, 1 bit per cycle.
REQ-026 MUL SHALL go BUSY->HOLD after DW cycles, so out_valid rises DW+1 cycles after acceptance; the output is the low DW bits when sat=0 and the product clamped to 2^DW-1 when sat=1.
REQ-027 MAC SHALL add the product into a 2*DW-bit accumulator that wraps, then go BUSY->IDLE without producing output.
REQ-028 FLUSH SHALL go IDLE->HOLD, with out_data = accumulator clamped to 2^DW-1 regardless of sat, and SHALL clear the accumulator to 0 in the same edge.
REQ-029 The DATA operand weight SHALL be weight[wsel] sampled at acceptance; LOAD_W packets cannot arrive during BUSY because in_ready=0.
REQ-030 In HOLD, out_valid=1 and out_data/out_dest/out_has_dest SHALL be stable until out_valid && out_ready, then the machine SHALL go HOLD->IDLE on that edge.
REQ-031 out_dest and out_has_dest SHALL be captured at acceptance of the producing packet, not at the output handshake.

Reset
REQ-032 On rst_n low, at any time including mid-BUSY or mid-HOLD, the tile SHALL enter IDLE and clear all weights, the accumulator and the product, set op=ADD, sat=0, wsel=0, dest=0, has_dest=0, out_valid=0 and out_data=0.
REQ-033 in_ready SHALL be 1 from the first clock edge after rst_n is deasserted; an operation in flight at reset SHALL produce no output.

Verification (DW=8, WDEPTH=4, NCORES=4)
REQ-034 Bench SHALL check: LOAD_W sel1=5; CONFIG op=ADD, sel1, dest=2; DATA 10 -> next cycle out_valid=1, out_data=15, out_dest=2, out_has_dest=1.
REQ-035 Bench SHALL check: weight=5, SUB, DATA 3 -> sat=0 gives 254; sat=1 gives 0. ADD 250+10 -> sat=0 gives 4; sat=1 gives 255.
REQ-036 Bench SHALL check: weight=20, MUL, DATA 20 -> out_valid exactly 9 cycles after acceptance; sat=0 gives 144; sat=1 gives 255; in_ready=0 throughout BUSY.
REQ-037 Bench SHALL check: weight=3, MAC, DATA 100 twice -> no out_valid; FLUSH -> 255 (acc=600); second FLUSH -> 0.
REQ-038 Bench SHALL check: out_ready held 0 for 5 cycles with a result pending -> out_data stable, in_ready=0, the next DATA is stalled, and it is accepted the cycle after the handshake.
REQ-039 Bench SHALL check: rst_n pulsed low 3 cycles into a MUL -> out_valid stays 0, in_ready=1, and weights read back as 0 (ADD DATA 7 -> 7).

Source files
------------

// File: rtl/compute_tile_pe.sv
`default_nettype none
// ============================================================================
// compute_tile_pe : weight-stationary PE with ADD/SUB/MAX, shift-add MUL/MAC
// Revision: 1.0
// ============================================================================
module compute_tile_pe #(
  parameter int DW     = 8,
  parameter int WDEPTH = 4,
  parameter int NCORES = 4,
  localparam int SELW  = (WDEPTH > 1) ? $clog2(WDEPTH) : 1,
  localparam int DSTW  = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_type,
  input  logic [SELW-1:0] in_sel,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [DSTW-1:0] out_dest,
  output logic            out_has_dest
);

  localparam int CNTW = $clog2(DW + 1);

  localparam logic [1:0] T_LOAD_W = 2'b00;
  localparam logic [1:0] T_CONFIG = 2'b01;
  localparam logic [1:0] T_DATA   = 2'b10;
  localparam logic [1:0] T_FLUSH  = 2'b11;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_MAC = 3'b011;
  localparam logic [2:0] OP_MAX = 3'b100;

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, HOLD = 2'b10} state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       weight_q [WDEPTH];
  logic [DW-1:0]       weight_d [WDEPTH];
  logic [2*DW-1:0]     acc_q, acc_d;
  logic [2*DW-1:0]     prod_q, prod_d;
  logic [2*DW-1:0]     mcand_q, mcand_d;
  logic [DW-1:0]       mplier_q, mplier_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                sat_q, sat_d;
  logic [SELW-1:0]     wsel_q, wsel_d;
  logic [DSTW-1:0]     dest_q, dest_d;
  logic                has_dest_q, has_dest_d;
  logic [DW-1:0]       out_data_q, out_data_d;
  logic [DSTW-1:0]     out_dest_q, out_dest_d;
  logic                out_has_dest_q, out_has_dest_d;

  logic [DW-1:0]       w_weight;
  logic [DW:0]         w_sum;
  logic [DW:0]         w_diff;
  logic                w_accept;

  // An out-of-range wsel (non power-of-two WDEPTH) reads as zero.
  assign w_weight = (int'(wsel_q) < WDEPTH) ? weight_q[wsel_q] : '0;
  assign w_sum    = {1'b0, in_data} + {1'b0, w_weight};
  assign w_diff   = {1'b0, in_data} - {1'b0, w_weight};
  assign w_accept = in_valid && (state_q == IDLE);

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == HOLD);
  assign out_data     = out_data_q;
  assign out_dest     = out_dest_q;
  assign out_has_dest = out_has_dest_q;

  always_comb begin
    state_d        = state_q;
    weight_d       = weight_q;
    acc_d          = acc_q;
    prod_d         = prod_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    sat_d          = sat_q;
    wsel_d         = wsel_q;
    dest_d         = dest_q;
    has_dest_d     = has_dest_q;
    out_data_d     = out_data_q;
    out_dest_d     = out_dest_q;
    out_has_dest_d = out_has_dest_q;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          case (in_type)
            T_LOAD_W: begin
              if (int'(in_sel) < WDEPTH) weight_d[in_sel] = in_data;
            end
            T_CONFIG: begin
              op_d       = in_data[2:0];
              sat_d      = in_data[3];
              dest_d     = in_data[4 +: DSTW];
              wsel_d     = in_sel;
              has_dest_d = 1'b1;
            end
            T_DATA: begin
              out_dest_d     = dest_q;
              out_has_dest_d = has_dest_q;
              case (op_q)
                OP_MUL, OP_MAC: begin
                  mcand_d  = {{DW{1'b0}}, w_weight};
                  mplier_d = in_data;
                  prod_d   = '0;
                  cnt_d    = '0;
                  state_d  = BUSY;
                end
                OP_SUB: begin
                  out_data_d = (sat_q && w_diff[DW]) ? '0 : w_diff[DW-1:0];
                  state_d    = HOLD;
                end
                OP_MAX: begin
                  out_data_d = (in_data > w_weight) ? in_data : w_weight;
                  state_d    = HOLD;
                end
                default: begin
                  out_data_d = (sat_q && w_sum[DW]) ? {DW{1'b1}} : w_sum[DW-1:0];
                  state_d    = HOLD;
                end
              endcase
            end
            T_FLUSH: begin
              out_data_d     = (acc_q[2*DW-1:DW] != '0) ? {DW{1'b1}} : acc_q[DW-1:0];
              out_dest_d     = dest_q;
              out_has_dest_d = has_dest_q;
              acc_d          = '0;
              state_d        = HOLD;
            end
            default: ;
          endcase
        end
      end
      BUSY: begin
        // DW shift-add steps, then one extra cycle to retire the product.
        if (cnt_q != CNTW'(DW)) begin
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNTW'(1);
        end else if (op_q == OP_MAC) begin
          acc_d   = acc_q + prod_q;
          state_d = IDLE;
        end else begin
          out_data_d = (sat_q && (prod_q[2*DW-1:DW] != '0)) ? {DW{1'b1}} : prod_q[DW-1:0];
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      weight_q       <= '{default: '0};
      acc_q          <= '0;
      prod_q         <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      cnt_q          <= '0;
      op_q           <= OP_ADD;
      sat_q          <= 1'b0;
      wsel_q         <= '0;
      dest_q         <= '0;
      has_dest_q     <= 1'b0;
      out_data_q     <= '0;
      out_dest_q     <= '0;
      out_has_dest_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      weight_q       <= weight_d;
      acc_q          <= acc_d;
      prod_q         <= prod_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      sat_q          <= sat_d;
      wsel_q         <= wsel_d;
      dest_q         <= dest_d;
      has_dest_q     <= has_dest_d;
      out_data_q     <= out_data_d;
      out_dest_q     <= out_dest_d;
      out_has_dest_q <= out_has_dest_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_compute_tile_pe.sv
`default_nettype none
// ============================================================================
// tb_compute_tile_pe : directed scoreboard bench for compute_tile_pe
// Revision: 1.0
// ============================================================================
module tb_compute_tile_pe;

  localparam logic [1:0] LOAD_W = 2'b00;
  localparam logic [1:0] CONFIG = 2'b01;
  localparam logic [1:0] DATA   = 2'b10;
  localparam logic [1:0] FLUSH  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_type = 2'b00;
  logic [1:0] in_sel = 2'b00;
  logic [7:0] in_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [1:0] out_dest;
  logic       out_has_dest;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] dest;
    logic       hd;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  compute_tile_pe #(.DW(8), .WDEPTH(4), .NCORES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_type      (in_type),
    .in_sel       (in_sel),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_dest     (out_dest),
    .out_has_dest (out_has_dest)
  );

  always #5 clk = ~clk;

  // Monitor: every output handshake retires the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got data=%0d dest=%0d has_dest=%0b, none expected",
                 out_data, out_dest, out_has_dest);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out_data !== e.d || out_dest !== e.dest || out_has_dest !== e.hd) begin
          bad++;
          $display("FAIL result: got data=%0d dest=%0d has_dest=%0b, want data=%0d dest=%0d has_dest=%0b",
                   out_data, out_dest, out_has_dest, e.d, e.dest, e.hd);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [7:0] d, input logic [1:0] dest, input logic hd);
    exp_t e;
    e.d = d; e.dest = dest; e.hd = hd;
    q.push_back(e);
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] t, input logic [1:0] s, input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1; in_type = t; in_sel = s; in_data = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready got 0 want 1 after %0d cycles", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic no_output(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    int lat;
    int busy_ok;
    int stable_ok;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_has_dest", int'(out_has_dest), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", int'(in_ready), 1);

    // ADD with destination
    send(LOAD_W, 2'd1, 8'd5);
    send(CONFIG, 2'd1, 8'h20);
    expect_out(8'd15, 2'd2, 1'b1);
    send(DATA, 2'd0, 8'd10);
    chk("add_next_cycle_valid", int'(out_valid), 1);
    chk("add_out_data", int'(out_data), 15);
    chk("add_out_dest", int'(out_dest), 2);

    // SUB wrap / clamp
    send(CONFIG, 2'd1, 8'h21);
    expect_out(8'd254, 2'd2, 1'b1);
    send(DATA, 2'd0, 8'd3);
    send(CONFIG, 2'd1, 8'h29);
    expect_out(8'd0, 2'd2, 1'b1);
    send(DATA, 2'd0, 8'd3);

    // ADD wrap / clamp
    send(LOAD_W, 2'd2, 8'd250);
    send(CONFIG, 2'd2, 8'h10);
    expect_out(8'd4, 2'd1, 1'b1);
    send(DATA, 2'd0, 8'd10);
    send(CONFIG, 2'd2, 8'h18);
    expect_out(8'd255, 2'd1, 1'b1);
    send(DATA, 2'd0, 8'd10);

    // MAX
    send(CONFIG, 2'd2, 8'h14);
    expect_out(8'd250, 2'd1, 1'b1);
    send(DATA, 2'd0, 8'd7);

    // MUL latency and saturation
    send(LOAD_W, 2'd0, 8'd20);
    send(CONFIG, 2'd0, 8'h32);
    expect_out(8'd144, 2'd3, 1'b1);
    send(DATA, 2'd0, 8'd20);
    lat = 0; busy_ok = 1;
    while (!out_valid && lat < 20) begin
      if (in_ready) busy_ok = 0;
      @(posedge clk); #1;
      lat++;
    end
    chk("mul_latency", lat, 9);
    chk("mul_busy_in_ready_low", busy_ok, 1);
    send(CONFIG, 2'd0, 8'h3A);
    expect_out(8'd255, 2'd3, 1'b1);
    send(DATA, 2'd0, 8'd20);

    // MAC accumulate then FLUSH twice
    send(LOAD_W, 2'd3, 8'd3);
    send(CONFIG, 2'd3, 8'h03);
    send(DATA, 2'd0, 8'd100);
    no_output("mac1_no_output", 12);
    send(DATA, 2'd0, 8'd100);
    no_output("mac2_no_output", 12);
    expect_out(8'd255, 2'd0, 1'b1);
    send(FLUSH, 2'd0, 8'd0);
    expect_out(8'd0, 2'd0, 1'b1);
    send(FLUSH, 2'd0, 8'd0);

    // Backpressure with a stalled follow-on packet
    send(CONFIG, 2'd1, 8'h20);
    out_ready = 1'b0;
    expect_out(8'd15, 2'd2, 1'b1);
    expect_out(8'd6, 2'd2, 1'b1);
    send(DATA, 2'd0, 8'd10);
    in_valid = 1'b1; in_type = DATA; in_sel = 2'd0; in_data = 8'd1;
    stable_ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!out_valid || out_data !== 8'd15 || in_ready) stable_ok = 0;
    end
    chk("stall_stable", stable_ok, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_released_in_ready", int'(in_ready), 1);
    chk("stall_released_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stalled_accept_next_cycle", int'(out_valid), 1);
    chk("stalled_out_data", int'(out_data), 6);

    // Reset in the middle of a MUL
    send(CONFIG, 2'd0, 8'h02);
    send(DATA, 2'd0, 8'd20);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", int'(out_valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postreset_in_ready", int'(in_ready), 1);
    no_output("postreset_no_output", 12);
    expect_out(8'd7, 2'd0, 1'b0);
    send(DATA, 2'd0, 8'd7);
    chk("postreset_add_valid", int'(out_valid), 1);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
